// File: rtl/reg_fifo_pkg.sv
// Shared definitions for the register FIFO: stage select codes
// and the level-width helper.
package reg_fifo_pkg;

   localparam logic [1:0] SEL_HOLD = 2'b00;
   localparam logic [1:0] SEL_NEXT = 2'b01;
   localparam logic [1:0] SEL_IN   = 2'b10;
   localparam logic [1:0] SEL_CLR  = 2'b11;

   function automatic int lw_f(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/reg_fifo_if.sv
// Producer/consumer bundle of the register FIFO.
interface reg_fifo_if #(
   parameter int WIDTH = 4,
   parameter int LW    = 3
);
   logic [WIDTH-1:0] si;
   logic             shift_in;
   logic             shift_out;
   logic             flush;
   logic [WIDTH-1:0] so;
   logic             empty;
   logic             full;
   logic [LW-1:0]    level;
   logic             almost_full;
   logic             almost_empty;
   logic             overflow;
   logic             underflow;

   modport master (
      output si, shift_in, shift_out, flush,
      input  so, empty, full, level,
      input  almost_full, almost_empty,
      input  overflow, underflow
   );

   modport slave (
      input  si, shift_in, shift_out, flush,
      output so, empty, full, level,
      output almost_full, almost_empty,
      output overflow, underflow
   );
endinterface

// File: rtl/reg_fifo_stage.sv
// One FIFO storage stage: data register plus valid bit,
// steered by a 2-bit select from the top level.
module reg_fifo_stage
   import reg_fifo_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             res_n,
   input  logic [1:0]       sel_i,
   input  logic [WIDTH-1:0] next_i,
   input  logic             next_vld_i,
   input  logic [WIDTH-1:0] si_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      unique case (sel_i)
         SEL_HOLD: ;
         SEL_NEXT: begin
            data_d  = next_i;
            valid_d = next_vld_i;
         end
         SEL_IN: begin
            data_d  = si_i;
            valid_d = 1'b1;
         end
         SEL_CLR: valid_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/reg_fifo.sv
// Register FIFO top: level counter, per-stage select generation,
// flag decode and registered overflow/underflow pulses.
module reg_fifo
   import reg_fifo_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int DEPTH    = 4,
   parameter int AF_LEVEL = 3,
   parameter int AE_LEVEL = 1
) (
   input  logic       clk,
   input  logic       res_n,
   reg_fifo_if.slave  bus
);

   localparam int LW = lw_f(DEPTH);
   localparam logic [LW-1:0] ONE  = LW'(1);
   localparam logic [LW-1:0] LMAX = LW'(DEPTH);

   logic [LW-1:0]    level_q, level_d, lvl_m1;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             full, empty;
   logic             push, pop;
   logic [1:0]       sel  [DEPTH];
   logic [WIDTH-1:0] data [DEPTH+1];
   logic             vld  [DEPTH+1];

   assign empty  = (level_q == '0);
   assign full   = (level_q == LMAX);
   assign lvl_m1 = level_q - ONE;
   assign pop    = bus.shift_out & ~empty;
   assign push   = bus.shift_in & (~full | pop);

   // Stage above the top one never feeds a valid entry.
   assign data[DEPTH] = '0;
   assign vld[DEPTH]  = 1'b0;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         sel[i] = SEL_HOLD;
         if (bus.flush) begin
            sel[i] = SEL_CLR;
         end else if (pop) begin
            if (LW'(i) < lvl_m1)
               sel[i] = SEL_NEXT;
            else if (LW'(i) == lvl_m1)
               sel[i] = push ? SEL_IN : SEL_CLR;
         end else if (push && LW'(i) == level_q) begin
            sel[i] = SEL_IN;
         end
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      reg_fifo_stage #(.WIDTH(WIDTH)) u_stage (
         .clk        (clk),
         .res_n      (res_n),
         .sel_i      (sel[g]),
         .next_i     (data[g+1]),
         .next_vld_i (vld[g+1]),
         .si_i       (bus.si),
         .data_o     (data[g]),
         .valid_o    (vld[g])
      );
   end

   always_comb begin
      level_d = level_q + LW'(push) - LW'(pop);
      ovf_d   = bus.shift_in & full & ~pop;
      unf_d   = bus.shift_out & empty;
      if (bus.flush) begin
         level_d = '0;
         ovf_d   = 1'b0;
         unf_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         level_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         level_q <= level_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Head valid bit must always agree with the level counter.
   a_head_vld: assert property (
      @(posedge clk) disable iff (!res_n) vld[0] == ~empty
   );

   assign bus.so           = data[0];
   assign bus.empty        = empty;
   assign bus.full         = full;
   assign bus.level        = level_q;
   assign bus.almost_full  = (level_q >= LW'(AF_LEVEL));
   assign bus.almost_empty = (level_q <= LW'(AE_LEVEL));
   assign bus.overflow     = ovf_q;
   assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_reg_fifo.sv
// Directed self-checking bench for reg_fifo (WIDTH=8, DEPTH=4).
module tb_reg_fifo;

   logic clk;
   logic res_n;
   int   n_cmp;
   int   n_bad;

   reg_fifo_if #(.WIDTH(8), .LW(3)) bif ();

   reg_fifo #(
      .WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)
   ) dut (
      .clk   (clk),
      .res_n (res_n),
      .bus   (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input logic [7:0] d, input logic sin,
                      input logic sout, input logic fl);
      bif.si        = d;
      bif.shift_in  = sin;
      bif.shift_out = sout;
      bif.flush     = fl;
      @(posedge clk);
      #1;
      bif.si        = '0;
      bif.shift_in  = 1'b0;
      bif.shift_out = 1'b0;
      bif.flush     = 1'b0;
   endtask

   task automatic flags(input string tag, input int lvl, input logic e,
                        input logic f, input logic af, input logic ae);
      check({tag, ".level"}, 32'(bif.level), 32'(lvl));
      check({tag, ".empty"}, 32'(bif.empty), 32'(e));
      check({tag, ".full"},  32'(bif.full),  32'(f));
      check({tag, ".af"},    32'(bif.almost_full),  32'(af));
      check({tag, ".ae"},    32'(bif.almost_empty), 32'(ae));
   endtask

   logic [7:0] exp2 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
   logic [7:0] exp3 [4] = '{8'h22, 8'h33, 8'h44, 8'h55};

   initial begin
      n_cmp = 0;
      n_bad = 0;
      res_n = 1'b0;
      bif.si = '0;
      bif.shift_in = 1'b0;
      bif.shift_out = 1'b0;
      bif.flush = 1'b0;
      #3;
      flags("rst", 0, 1, 0, 0, 1);
      check("rst.so",  32'(bif.so), 32'h0);
      check("rst.ovf", 32'(bif.overflow), 0);
      check("rst.unf", 32'(bif.underflow), 0);
      @(negedge clk);
      res_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: fill
      cyc(8'h11, 1, 0, 0);
      flags("p1", 1, 0, 0, 0, 1);
      check("p1.so", 32'(bif.so), 32'h11);
      cyc(8'h22, 1, 0, 0);
      flags("p2", 2, 0, 0, 0, 0);
      cyc(8'h33, 1, 0, 0);
      flags("p3", 3, 0, 0, 1, 0);
      cyc(8'h44, 1, 0, 0);
      flags("p4", 4, 0, 1, 1, 0);
      check("p4.so", 32'(bif.so), 32'h11);

      // 2: overflow while full
      cyc(8'h55, 1, 0, 0);
      check("ovf.pulse", 32'(bif.overflow), 1);
      check("ovf.level", 32'(bif.level), 4);
      check("ovf.so",    32'(bif.so), 32'h11);
      cyc(8'h00, 0, 0, 0);
      check("ovf.clear", 32'(bif.overflow), 0);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("drain2[%0d]", k), 32'(bif.so), 32'(exp2[k]));
         cyc(8'h00, 0, 1, 0);
      end
      flags("drain2.end", 0, 1, 0, 0, 1);
      check("drain2.hold", 32'(bif.so), 32'h44);
      check("drain2.unf", 32'(bif.underflow), 0);

      // 3: push+pop while full
      cyc(8'h11, 1, 0, 0);
      cyc(8'h22, 1, 0, 0);
      cyc(8'h33, 1, 0, 0);
      cyc(8'h44, 1, 0, 0);
      cyc(8'h55, 1, 1, 0);
      check("pp.so",    32'(bif.so), 32'h22);
      check("pp.level", 32'(bif.level), 4);
      check("pp.ovf",   32'(bif.overflow), 0);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("drain3[%0d]", k), 32'(bif.so), 32'(exp3[k]));
         cyc(8'h00, 0, 1, 0);
      end
      check("drain3.empty", 32'(bif.empty), 1);

      // 4: pop+push on empty
      cyc(8'hA5, 1, 1, 0);
      check("unf.pulse", 32'(bif.underflow), 1);
      check("unf.level", 32'(bif.level), 1);
      check("unf.so",    32'(bif.so), 32'hA5);
      cyc(8'h00, 0, 0, 0);
      check("unf.clear", 32'(bif.underflow), 0);

      // 5: flush wins over push
      cyc(8'h01, 1, 0, 0);
      cyc(8'h02, 1, 0, 0);
      check("fl.pre", 32'(bif.level), 3);
      cyc(8'h77, 1, 0, 1);
      flags("fl", 0, 1, 0, 0, 1);
      check("fl.ovf", 32'(bif.overflow), 0);
      check("fl.unf", 32'(bif.underflow), 0);
      check("fl.hold", 32'(bif.so), 32'hA5);
      cyc(8'h88, 1, 0, 0);
      check("fl.next.level", 32'(bif.level), 1);
      check("fl.next.so",    32'(bif.so), 32'h88);
      cyc(8'h00, 0, 1, 0);
      check("fl.next.empty", 32'(bif.empty), 1);

      // 6: async reset mid-cycle
      cyc(8'hC1, 1, 0, 0);
      cyc(8'hC2, 1, 0, 0);
      check("ar.pre", 32'(bif.level), 2);
      #2;
      res_n = 1'b0;
      #1;
      flags("ar", 0, 1, 0, 0, 1);
      check("ar.so", 32'(bif.so), 32'h0);
      @(negedge clk);
      res_n = 1'b1;
      @(posedge clk);
      #1;
      check("ar.after", 32'(bif.level), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
